sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Responder side of the datapath memory bus: accepts single-word read/write requests issued by the MAR/MDR logic and sequences the asynchronous SRAM strobes with a fixed number of wait states. Returns read data and a one-cycle completion pulse that the control FSM uses to leave its memory-wait states. Sits between the datapath bus logic and the top-level SRAM pins; the top level owns the tri-state data buffer.

## Interface
Parameters:
- ADDR_W, 16, request and SRAM address width
- DATA_W, 16, data word width
- WAIT_CYCLES, 2, strobe-active cycles per access; must be >= 1 (elaboration-time assertion)

Ports:
- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  **asynchronous, active-high**; returns block to IDLE immediately
- Req_Valid  in  1  request present; requester holds all Req_* stable until accepted
- Req_Ready  out  1  high only in IDLE; accept = Req_Valid & Req_Ready at a rising edge
- Req_Write  in  1  1 = write, 0 = read
- Req_Addr  in  ADDR_W  word address
- Req_Wdata  in  DATA_W  write data
- Rsp_Valid  out  1  one-cycle completion pulse (reads and writes)
- Rsp_Rdata  out  DATA_W  last read data; held until next read completes
- Mem_Addr  out  ADDR_W  SRAM address
- Mem_CE_N, Mem_OE_N, Mem_WE_N  out  1 each  SRAM strobes, active-low
- Mem_Dout  out  DATA_W  write data to pad buffer
- Mem_Dout_En  out  1  pad buffer drive enable
- Mem_Din  in  DATA_W  read data from pads

## Operation
- States: IDLE, SETUP, ACCESS, RECOVER.
- IDLE: Req_Ready=1, all strobes high, Dout_En=0. On accept: latch Req_Write, Req_Addr, Req_Wdata; -> SETUP.
- SETUP (1 cycle): Mem_Addr = latched address, CE_N=0, OE_N=WE_N=1; write: Dout_En=1. -> ACCESS, wait counter loaded with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles): CE_N=0; read: OE_N=0; write: WE_N=0, Dout_En=1. Counter decrements; at 0 -> RECOVER. On the final ACCESS edge a read captures Mem_Din into Rsp_Rdata.
- RECOVER (1 cycle): OE_N=WE_N=1, CE_N=0, write keeps Dout_En=1 (data hold); Rsp_Valid=1. -> IDLE.
- Rsp_Rdata untouched by writes.
- Req_* changes while busy have no effect (latched copies drive pins).
- Req_Valid during RECOVER is not accepted; acceptance occurs the following IDLE cycle.
- Reset mid-transaction: abort, no Rsp_Valid, strobes high, Dout_En low; Rsp_Rdata cleared.

## Timing
- Reset values: Req_Ready=1, Rsp_Valid=0, Rsp_Rdata=0, Mem_Addr=0, CE_N=OE_N=WE_N=1, Mem_Dout=0, Dout_En=0.
- All outputs driven from flops (Req_Ready may decode state register directly); no combinational path from Req_* or Mem_Din to any output.
- Accept at edge k: SETUP k+1, ACCESS k+2..k+1+W, RECOVER (Rsp_Valid) k+2+W, IDLE k+3+W (W = WAIT_CYCLES).
- Max throughput: one transaction per W+3 cycles.
- Mem_Addr stable from SETUP through RECOVER; strobes never active outside CE_N=0 window.
- Counter width $clog2(WAIT_CYCLES+1).

## Structure
- Package mem_ctrl_pkg: typedef enum mem_state_t {IDLE, SETUP, ACCESS, RECOVER}; default width constants.
- One sub-module: wait_counter (load, decrement, zero flag, async active-high reset).

## Test plan
(W=2, accept at edge k)
- Reset asserted then released -> all outputs at reset values above, Req_Ready=1.
- Read 0x3000, Mem_Din=0xBEEF during ACCESS -> OE_N low k+2..k+3, Rsp_Valid=1 at k+4 only, Rsp_Rdata=0xBEEF from k+4 on.
- Write 0x0042 data 0x1234 -> WE_N low k+2..k+3, Dout_En high k+1..k+4, Mem_Dout=0x1234, Rsp_Valid at k+4, Rsp_Rdata unchanged.
- Req_Valid held high for read then write -> second accepted at k+5; no overlap of strobe windows.
- Req_Addr changed to 0xFFFF during ACCESS -> Mem_Addr stays 0x3000 until IDLE.
- Reset pulsed during ACCESS of a read -> strobes high and Dout_En low without waiting for edge, no Rsp_Valid; next read completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the SRAM access controller.
// Imported by the controller top and its wait-state counter.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER
  } mem_state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_DEF   = 2;

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter: load WAIT_CYCLES-1, decrement, zero flag.
// Saturates at zero so a stray decrement cannot wrap.
module wait_counter #(
  parameter int WAIT_CYCLES = 2,
  localparam int CW = $clog2(WAIT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CW-1:0] cnt;

  // count register: load has priority over decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CW'(WAIT_CYCLES - 1);
    else if (dec && cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-word SRAM responder: sequences CE/OE/WE with fixed wait states.
// Outputs are registered from next-state so no input reaches a pin combinationally.
module sram_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_Wdata,
  output logic              Rsp_Valid,
  output logic [DATA_W-1:0] Rsp_Rdata,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_CE_N,
  output logic              Mem_OE_N,
  output logic              Mem_WE_N,
  output logic [DATA_W-1:0] Mem_Dout,
  output logic              Mem_Dout_En,
  input  logic [DATA_W-1:0] Mem_Din
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("WAIT_CYCLES must be >= 1");
  end

  mem_state_t state, state_d;
  logic       wr_q, wr_d;
  logic       ce_d, oe_d, we_d, den_d, rv_d;
  logic       accept, zero;

  assign Req_Ready = (state == IDLE);
  assign accept    = Req_Valid & Req_Ready;

  wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk (Clk),
    .rst (Reset),
    .load(state == SETUP),
    .dec (state == ACCESS),
    .zero(zero)
  );

  // next state plus the strobe values that state will present
  always_comb begin
    state_d = state;
    wr_d    = wr_q;
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    den_d   = 1'b0;
    rv_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          wr_d    = Req_Write;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (zero) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      SETUP: begin
        ce_d  = 1'b0;
        den_d = wr_d;
      end
      ACCESS: begin
        ce_d  = 1'b0;
        oe_d  = wr_d;
        we_d  = ~wr_d;
        den_d = wr_d;
      end
      RECOVER: begin
        ce_d  = 1'b0;
        den_d = wr_d;
        rv_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // state and latched direction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      wr_q  <= 1'b0;
    end else begin
      state <= state_d;
      wr_q  <= wr_d;
    end
  end

  // registered pins, request latches and read capture
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Mem_CE_N    <= 1'b1;
      Mem_OE_N    <= 1'b1;
      Mem_WE_N    <= 1'b1;
      Mem_Dout_En <= 1'b0;
      Rsp_Valid   <= 1'b0;
      Mem_Addr    <= '0;
      Mem_Dout    <= '0;
      Rsp_Rdata   <= '0;
    end else begin
      Mem_CE_N    <= ce_d;
      Mem_OE_N    <= oe_d;
      Mem_WE_N    <= we_d;
      Mem_Dout_En <= den_d;
      Rsp_Valid   <= rv_d;
      if (accept) begin
        Mem_Addr <= Req_Addr;
        Mem_Dout <= Req_Wdata;
      end
      if (state == ACCESS && zero && !wr_q)
        Rsp_Rdata <= Mem_Din;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl (W=2) with a response scoreboard.
// Stimulus pushes expected read data; a monitor pops on each Rsp_Valid.
module tb_sram_access_ctrl;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req_Valid, Req_Ready, Req_Write;
  logic [15:0] Req_Addr, Req_Wdata;
  logic        Rsp_Valid;
  logic [15:0] Rsp_Rdata, Mem_Addr, Mem_Dout, Mem_Din;
  logic        Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_Dout_En;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] expq[$];
  logic [15:0] model_rd = 16'h0;
  int          k1, k2, k3, k4, k5, k6;

  sram_access_ctrl #(
    .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Write(Req_Write), .Req_Addr(Req_Addr),
    .Req_Wdata(Req_Wdata),
    .Rsp_Valid(Rsp_Valid), .Rsp_Rdata(Rsp_Rdata),
    .Mem_Addr(Mem_Addr), .Mem_CE_N(Mem_CE_N),
    .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N),
    .Mem_Dout(Mem_Dout), .Mem_Dout_En(Mem_Dout_En),
    .Mem_Din(Mem_Din)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && Rsp_Valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata %h expected none",
                 Rsp_Rdata);
      end else begin
        chk("rsp_rdata", Rsp_Rdata, expq.pop_front());
      end
    end
  end

  task automatic txn(input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] din,
                     input bit hold, output int k);
    int t;
    t = 0;
    k = cyc;
    Req_Write = w;
    Req_Addr  = a;
    Req_Wdata = d;
    Req_Valid = 1'b1;
    while (!Req_Ready && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!Req_Ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      Req_Valid = 1'b0;
      return;
    end
    if (w) expq.push_back(model_rd);
    else begin
      expq.push_back(din);
      model_rd = din;
    end
    @(posedge Clk);
    #1;
    k = cyc;
    if (!hold) Req_Valid = 1'b0;
    Req_Addr  = 16'hFFFF;
    Req_Wdata = 16'hDEAD;
    Req_Write = ~w;
    Mem_Din   = din;
    @(negedge Clk);
    chk("setup_ce", Mem_CE_N, 0);
    chk("setup_oe", Mem_OE_N, 1);
    chk("setup_we", Mem_WE_N, 1);
    chk("setup_den", Mem_Dout_En, w);
    chk("setup_addr", Mem_Addr, a);
    chk("setup_ready", Req_Ready, 0);
    for (int i = 0; i < W; i++) begin
      @(negedge Clk);
      chk("acc_ce", Mem_CE_N, 0);
      chk("acc_oe", Mem_OE_N, w);
      chk("acc_we", Mem_WE_N, !w);
      chk("acc_den", Mem_Dout_En, w);
      chk("acc_addr", Mem_Addr, a);
      chk("acc_rv", Rsp_Valid, 0);
      if (w) chk("acc_dout", Mem_Dout, d);
    end
    @(negedge Clk);
    Mem_Din = 16'h5A5A;
    chk("rec_rv", Rsp_Valid, 1);
    chk("rec_ce", Mem_CE_N, 0);
    chk("rec_oe", Mem_OE_N, 1);
    chk("rec_we", Mem_WE_N, 1);
    chk("rec_den", Mem_Dout_En, w);
    chk("rec_addr", Mem_Addr, a);
    chk("rec_ready", Req_Ready, 0);
    @(negedge Clk);
    chk("idle_rv", Rsp_Valid, 0);
    chk("idle_ce", Mem_CE_N, 1);
    chk("idle_den", Mem_Dout_En, 0);
    chk("idle_ready", Req_Ready, 1);
    chk("idle_rdata", Rsp_Rdata, model_rd);
  endtask

  initial begin
    Reset     = 1'b1;
    Req_Valid = 1'b0;
    Req_Write = 1'b0;
    Req_Addr  = 16'h0;
    Req_Wdata = 16'h0;
    Mem_Din   = 16'h0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", Req_Ready, 1);
    chk("rst_rv", Rsp_Valid, 0);
    chk("rst_rdata", Rsp_Rdata, 0);
    chk("rst_addr", Mem_Addr, 0);
    chk("rst_ce", Mem_CE_N, 1);
    chk("rst_oe", Mem_OE_N, 1);
    chk("rst_we", Mem_WE_N, 1);
    chk("rst_dout", Mem_Dout, 0);
    chk("rst_den", Mem_Dout_En, 0);
    Reset = 1'b0;
    @(negedge Clk);

    txn(1'b0, 16'h3000, 16'h0000, 16'hBEEF, 1'b0, k1);
    txn(1'b1, 16'h0042, 16'h1234, 16'h0BAD, 1'b0, k2);
    txn(1'b0, 16'h0100, 16'h0000, 16'hA5A5, 1'b1, k3);
    txn(1'b1, 16'h0101, 16'h7777, 16'h0000, 1'b0, k4);
    chk("b2b_gap", k4 - k3, 5);
    txn(1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, k5);

    Req_Write = 1'b0;
    Req_Addr  = 16'h2222;
    Req_Valid = 1'b1;
    Mem_Din   = 16'h1111;
    @(posedge Clk);
    #1;
    Req_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_pre_oe", Mem_OE_N, 0);
    #2;
    Reset = 1'b1;
    #1;
    chk("abort_ce", Mem_CE_N, 1);
    chk("abort_oe", Mem_OE_N, 1);
    chk("abort_we", Mem_WE_N, 1);
    chk("abort_den", Mem_Dout_En, 0);
    chk("abort_rv", Rsp_Valid, 0);
    chk("abort_rdata", Rsp_Rdata, 0);
    chk("abort_ready", Req_Ready, 1);
    @(negedge Clk);
    Reset = 1'b0;
    model_rd = 16'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("abort_no_rsp", Rsp_Valid, 0);
    end

    txn(1'b0, 16'h1234, 16'h0000, 16'h0F0F, 1'b0, k6);
    repeat (2) @(negedge Clk);
    chk("queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
